// File: rtl/kbd_event_fifo_pkg.sv
// Shared keyboard definitions: event word layout and the empty-register sentinel.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package kbd_event_fifo_pkg;

    localparam int KBD_EVT_W     = 16;
    localparam int KBD_ASCII_LSB = 0;
    localparam int KBD_ASCII_MSB = 7;
    localparam int KBD_BREAK_BIT = 8;

    localparam logic [KBD_EVT_W-1:0] KBD_NO_EVENT = 16'h0000;

    // Decoded event word as produced by the PS/2 decode stage.
    typedef struct packed {
        logic [6:0] rsvd;
        logic       brk;
        logic [7:0] ascii;
    } kbd_evt_t;

endpackage

// File: rtl/kbd_event_fifo_if.sv
// Bundle between PS/2 decoder / CPU register side (master) and the event FIFO (slave).
// Latency: n/a (wiring only).
// Backpressure: none; the producer strobe is never stalled.
interface kbd_event_fifo_if #(
    parameter int DEPTH = 16
);
    import kbd_event_fifo_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic [KBD_EVT_W-1:0] in_data;
    logic                 ren;
    logic                 clr_ovf;
    logic [KBD_EVT_W-1:0] rdata;
    logic                 empty;
    logic [CW-1:0]        count;
    logic                 overflow;
    logic [7:0]           drop_cnt;
    logic                 irq;

    modport master (
        output in_valid, in_data, ren, clr_ovf,
        input  rdata, empty, count, overflow, drop_cnt, irq
    );

    modport slave (
        input  in_valid, in_data, ren, clr_ovf,
        output rdata, empty, count, overflow, drop_cnt, irq
    );

endinterface

// File: rtl/kbd_event_fifo.sv
// Keyboard event FIFO: holds decoded PS/2 events until the CPU reads them in order.
// Latency: a push is visible next cycle; rdata is a combinational read of the head entry.
// Backpressure: none to the producer; when full, new events are dropped and counted.
module kbd_event_fifo
    import kbd_event_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter bit DROP_BREAKS = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    kbd_event_fifo_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    kbd_evt_t       mem [DEPTH];
    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic [CW-1:0]  count;
    logic           overflow;
    logic [7:0]     drop_cnt;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic store;
    logic drop;

    // Accept/pop decisions; a pop while full frees the slot the new event takes.
    always_comb begin
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
        push  = bus.in_valid && !(DROP_BREAKS && bus.in_data[KBD_BREAK_BIT]);
        pop   = bus.ren && !empty;
        store = push && (!full || pop);
        drop  = push && full && !pop;
    end

    // Event storage; deliberately not reset, the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && store) begin
            mem[wp] <= bus.in_data;
        end
    end

    // Pointers, occupancy and overflow bookkeeping; a drop beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            if (store) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (store && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !store) begin
                count <= count - 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (bus.clr_ovf) begin
                    drop_cnt <= 8'h01;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'h01;
                end
            end else if (bus.clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= 8'h00;
            end
        end
    end

    assign bus.rdata    = empty ? KBD_NO_EVENT : KBD_EVT_W'(mem[rp]);
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.drop_cnt = drop_cnt;
    assign bus.irq      = !empty;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Self-checking bench for kbd_event_fifo: scoreboard queue of stored events, read monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_kbd_event_fifo;
    import kbd_event_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    kbd_event_fifo_if #(.DEPTH(DEPTH)) bus ();
    kbd_event_fifo_if #(.DEPTH(DEPTH)) bus2 ();

    kbd_event_fifo #(.DEPTH(DEPTH), .DROP_BREAKS(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    kbd_event_fifo #(.DEPTH(DEPTH), .DROP_BREAKS(1'b1)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every CPU read cycle is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.ren === 1'b1) begin
            if (exp_q.size() == 0) begin
                mon_exp = KBD_NO_EVENT;
            end else begin
                mon_exp = exp_q.pop_front();
            end
            checks++;
            if (bus.rdata !== mon_exp) begin
                failures++;
                $display("FAIL read_data: got %h expected %h", bus.rdata, mon_exp);
            end
        end
    end

    // One bus cycle; the model is updated after the monitor has seen this cycle's read.
    task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.ren      = r;
        bus.clr_ovf  = c;
        @(negedge clk);
        #1;
        if (v && exp_q.size() < DEPTH) exp_q.push_back(d);
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.ren       = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = 16'h0000;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        exp_q.delete();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.ren       = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = 16'h0000;
        bus2.ren      = 1'b0;
        bus2.clr_ovf  = 1'b0;

        // Reset state
        do_reset(1'b0, 16'h0000);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_irq", int'(bus.irq), 0);
        chk("rst_rdata", int'(bus.rdata), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_drop_cnt", int'(bus.drop_cnt), 0);

        // Basic ordering and read of an empty FIFO
        drive(1'b1, 16'h0061, 1'b0, 1'b0);
        drive(1'b1, 16'h0062, 1'b0, 1'b0);
        drive(1'b1, 16'h0161, 1'b0, 1'b0);
        idle();
        chk("t1_count", int'(bus.count), 3);
        chk("t1_head", int'(bus.rdata), 16'h0061);
        chk("t1_irq", int'(bus.irq), 1);
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        idle();
        chk("t1_empty", int'(bus.empty), 1);
        chk("t1_irq_low", int'(bus.irq), 0);
        chk("t1_rdata_zero", int'(bus.rdata), 0);

        // Overflow on a full FIFO
        do_reset(1'b0, 16'h0000);
        for (int i = 0; i < 20; i++) drive(1'b1, 16'h0041 + 16'(i), 1'b0, 1'b0);
        idle();
        chk("t2_count", int'(bus.count), 16);
        chk("t2_overflow", int'(bus.overflow), 1);
        chk("t2_drop_cnt", int'(bus.drop_cnt), 4);
        chk("t2_head", int'(bus.rdata), 16'h0041);
        for (int i = 0; i < 17; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        idle();
        chk("t2_empty", int'(bus.empty), 1);

        // Push and pop together while full
        do_reset(1'b0, 16'h0000);
        for (int i = 0; i < 16; i++) drive(1'b1, 16'h0041 + 16'(i), 1'b0, 1'b0);
        drive(1'b1, 16'h0078, 1'b1, 1'b0);
        idle();
        chk("t3_count", int'(bus.count), 16);
        chk("t3_overflow", int'(bus.overflow), 0);
        chk("t3_drop_cnt", int'(bus.drop_cnt), 0);
        chk("t3_head", int'(bus.rdata), 16'h0042);
        for (int i = 0; i < 16; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        idle();
        chk("t3_empty", int'(bus.empty), 1);

        // Saturating drop counter, clear, and drop winning over clear
        do_reset(1'b0, 16'h0000);
        for (int i = 0; i < 300; i++) drive(1'b1, 16'h0041 + 16'(i % 16), 1'b0, 1'b0);
        idle();
        chk("t4_drop_sat", int'(bus.drop_cnt), 8'hFF);
        chk("t4_overflow", int'(bus.overflow), 1);
        chk("t4_count", int'(bus.count), 16);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        idle();
        chk("t4_clr_overflow", int'(bus.overflow), 0);
        chk("t4_clr_drop_cnt", int'(bus.drop_cnt), 0);
        chk("t4_clr_count", int'(bus.count), 16);
        chk("t4_clr_head", int'(bus.rdata), 16'h0041);
        drive(1'b1, 16'h0070, 1'b0, 1'b1);
        idle();
        chk("t4_drop_wins_ovf", int'(bus.overflow), 1);
        chk("t4_drop_wins_cnt", int'(bus.drop_cnt), 1);
        for (int i = 0; i < 16; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        idle();
        chk("t4_empty", int'(bus.empty), 1);

        // Break filtering on the DROP_BREAKS instance
        do_reset(1'b0, 16'h0000);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b1;
        bus2.in_data  = 16'h0161;
        @(posedge clk);
        #1;
        bus2.in_data  = 16'h0061;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        bus2.in_data  = 16'h0000;
        chk("t5_count", int'(bus2.count), 1);
        chk("t5_head", int'(bus2.rdata), 16'h0061);
        chk("t5_overflow", int'(bus2.overflow), 0);
        chk("t5_drop_cnt", int'(bus2.drop_cnt), 0);

        // Reset beats a coincident push
        do_reset(1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h0030 + 16'(i), 1'b0, 1'b0);
        idle();
        chk("t6_pre_count", int'(bus.count), 5);
        do_reset(1'b1, 16'h0055);
        chk("t6_count", int'(bus.count), 0);
        chk("t6_rdata", int'(bus.rdata), 0);
        chk("t6_empty", int'(bus.empty), 1);

        // Pointer wrap: streaming push/pop pairs across three laps
        for (int i = 0; i < 3 * DEPTH; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
        idle();
        chk("t6_wrap_count", int'(bus.count), 1);
        chk("t6_wrap_head", int'(bus.rdata), 3 * DEPTH - 1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        idle();
        chk("t6_wrap_empty", int'(bus.empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
